// File: rtl/ps2_key_sequencer_if.sv
// Bus between the PS/2 key sequencer, its receiver/lookup and the CPU read port.
// The master side drives scan bytes, lookup results and the pop/clear strobes.
interface ps2_key_sequencer_if #(
  parameter int AW = 3
);
  logic [7:0]  scan_code;
  logic        scan_valid;
  logic [7:0]  key_code;
  logic [7:0]  ascii_code;
  logic        rd_en;
  logic [7:0]  data_out;
  logic        empty;
  logic        full;
  logic [AW:0] count;
  logic        overflow;
  logic        overrun;
  logic        clr_err;

  modport master (
    output scan_code, scan_valid, ascii_code, rd_en, clr_err,
    input  key_code, data_out, empty, full, count, overflow, overrun
  );

  modport slave (
    input  scan_code, scan_valid, ascii_code, rd_en, clr_err,
    output key_code, data_out, empty, full, count, overflow, overrun
  );
endinterface

// File: rtl/ps2_key_sequencer.sv
// PS/2 set-2 make/break/extended decoder feeding an ASCII lookup, with a FWFT char FIFO.
// Optional SHIFT_CASE_EN: track L/R shift and fold unshifted A..Z to lower case.
module ps2_key_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ps2_key_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK,
    S_LOOKUP
  } state_t;

  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  state_t      state_q, state_d;
  logic [7:0]  key_code_q, key_code_d;
  logic        overrun_q, overrun_d;
  logic        overflow_q, overflow_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];

  logic        is_shift;
  logic        overrun_set;
  logic        push_req;
  logic        do_push;
  logic        do_pop;
  logic        overflow_set;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  push_data;

  assign is_shift = (bus.scan_code == SC_LSHIFT) || (bus.scan_code == SC_RSHIFT);

  // Decoder: every state but LOOKUP waits for a scan strobe.
  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code_q;
    overrun_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.scan_valid) begin
          if (bus.scan_code == SC_BRK) begin
            state_d = S_BRK;
          end else if (bus.scan_code == SC_EXT) begin
            state_d = S_EXT;
          end else if (!is_shift) begin
            state_d    = S_LOOKUP;
            key_code_d = bus.scan_code;
          end
        end
      end
      S_BRK: begin
        if (bus.scan_valid) state_d = S_IDLE;
      end
      S_EXT: begin
        if (bus.scan_valid) state_d = (bus.scan_code == SC_BRK) ? S_EXT_BRK : S_IDLE;
      end
      S_EXT_BRK: begin
        if (bus.scan_valid) state_d = S_IDLE;
      end
      S_LOOKUP: begin
        state_d     = S_IDLE;
        overrun_set = bus.scan_valid;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SHIFT_CASE_EN
  logic [1:0] shift_q, shift_d;

  always_comb begin
    shift_d = shift_q;
    if (bus.scan_valid && (state_q == S_IDLE)) begin
      if (bus.scan_code == SC_LSHIFT) shift_d[0] = 1'b1;
      if (bus.scan_code == SC_RSHIFT) shift_d[1] = 1'b1;
    end else if (bus.scan_valid && (state_q == S_BRK)) begin
      if (bus.scan_code == SC_LSHIFT) shift_d[0] = 1'b0;
      if (bus.scan_code == SC_RSHIFT) shift_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) shift_q <= 2'b00;
    else          shift_q <= shift_d;
  end

  function automatic logic [7:0] fold_case(input logic [7:0] a, input logic shift_held);
    if (!shift_held && (a >= 8'h41) && (a <= 8'h5A)) return a + 8'h20;
    return a;
  endfunction

  assign push_data = fold_case(bus.ascii_code, |shift_q);
`else
  assign push_data = bus.ascii_code;
`endif

  // FIFO: one extra pointer bit separates full from empty.
  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_req     = (state_q == S_LOOKUP);
  assign do_pop       = bus.rd_en && !fifo_empty;
  assign do_push      = push_req && (!fifo_full || do_pop);
  assign overflow_set = push_req && fifo_full && !do_pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, do_pop};
    overflow_d = (overflow_q && !bus.clr_err) || overflow_set;
    overrun_d  = (overrun_q  && !bus.clr_err) || overrun_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      key_code_q <= 8'h00;
      overrun_q  <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      key_code_q <= key_code_d;
      overrun_q  <= overrun_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage is not reset; the empty mux hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign bus.key_code = key_code_q;
  assign bus.data_out = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.empty    = fifo_empty;
  assign bus.full     = fifo_full;
  assign bus.count    = wr_ptr_q - rd_ptr_q;
  assign bus.overflow = overflow_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: directed scenarios then random bytes, checked by a
// queue-based reference model and a monitor that compares on every cycle and pop.
module tb_ps2_key_sequencer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  ps2_key_sequencer_if #(.AW(AW)) bus ();
  ps2_key_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] lut(input logic [7:0] k);
    case (k)
      8'h1C: return 8'h41;
      8'h32: return 8'h42;
      8'h21: return 8'h43;
      8'h23: return 8'h44;
      8'h16: return 8'h31;
      8'h1E: return 8'h32;
      8'h45: return 8'h30;
      8'h29: return 8'h20;
      default: return 8'h3F;
    endcase
  endfunction

  always_comb bus.ascii_code = lut(bus.key_code);

  function automatic logic [7:0] expect_char(input logic [7:0] a, input bit shifted);
`ifdef SHIFT_CASE_EN
    if (!shifted && a >= 8'h41 && a <= 8'h5A) return a + 8'h20;
`endif
    return a;
  endfunction

`ifdef SHIFT_CASE_EN
  localparam logic [7:0] A_PLAIN = 8'h61;
`else
  localparam logic [7:0] A_PLAIN = 8'h41;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: protocol prefix flags plus a queue of chars the FIFO should hold.
  logic [7:0] exp_q[$];
  bit m_brk, m_ext, m_lsh, m_rsh, m_pend, m_ovf, m_ovr;
  logic [7:0] m_pend_char;

  always @(posedge clk or negedge reset_n) begin
    bit ovf_ev, ovr_ev, new_pend;
    logic [7:0] b, new_char;
    if (!reset_n) begin
      exp_q.delete();
      m_brk = 0; m_ext = 0; m_lsh = 0; m_rsh = 0;
      m_pend = 0; m_ovf = 0; m_ovr = 0; m_pend_char = 8'h00;
    end else begin
      ovf_ev = 0; ovr_ev = 0; new_pend = 0; new_char = 8'h00;
      if (bus.rd_en && exp_q.size() > 0) void'(exp_q.pop_front());
      if (m_pend) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(m_pend_char);
        else ovf_ev = 1;
      end
      if (bus.scan_valid) begin
        b = bus.scan_code;
        if (m_pend) ovr_ev = 1;
        else if (m_brk) begin
          if (!m_ext && b == 8'h12) m_lsh = 0;
          if (!m_ext && b == 8'h59) m_rsh = 0;
          m_brk = 0; m_ext = 0;
        end else if (b == 8'hF0) m_brk = 1;
        else if (m_ext) m_ext = 0;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'h12) m_lsh = 1;
        else if (b == 8'h59) m_rsh = 1;
        else begin
          new_pend = 1;
          new_char = expect_char(lut(b), m_lsh || m_rsh);
        end
      end
      m_pend = new_pend;
      m_pend_char = new_char;
      m_ovf = (m_ovf && !bus.clr_err) || ovf_ev;
      m_ovr = (m_ovr && !bus.clr_err) || ovr_ev;
    end
  end

  // Monitor: status every cycle, head value whenever the DUT presents a popped entry.
  always @(negedge clk) begin
    check("count", 32'(bus.count), 32'(exp_q.size()));
    check("empty", 32'(bus.empty), 32'(exp_q.size() == 0));
    check("full", 32'(bus.full), 32'(exp_q.size() == DEPTH));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("overrun", 32'(bus.overrun), 32'(m_ovr));
    if (bus.rd_en && !bus.empty) begin
      if (exp_q.size() == 0) check("pop_unexpected", 32'(bus.data_out), 32'hFFFF_FFFF);
      else check("pop_data", 32'(bus.data_out), 32'(exp_q[0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.scan_code  = b;
    bus.scan_valid = 1'b1;
    tick();
    bus.scan_valid = 1'b0;
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic clear_err();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_key_code"}, 32'(bus.key_code), 32'h00);
    check({tag, "_data_out"}, 32'(bus.data_out), 32'h00);
    check({tag, "_empty"}, 32'(bus.empty), 32'h1);
    check({tag, "_full"}, 32'(bus.full), 32'h0);
    check({tag, "_count"}, 32'(bus.count), 32'h0);
    check({tag, "_overflow"}, 32'(bus.overflow), 32'h0);
    check({tag, "_overrun"}, 32'(bus.overrun), 32'h0);
  endtask

  logic [7:0] seq2 [0:6] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
  logic [7:0] seq3 [0:4] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
  logic [7:0] pool [0:11] = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h45, 8'h12,
                              8'h59, 8'hF0, 8'hE0, 8'h75, 8'h29, 8'h0D};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run still active, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.scan_code = 8'h00; bus.scan_valid = 1'b0; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
    #1 reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values("rst");

    // 1: make then break of 1C
    send_byte(8'h1C);
    @(negedge clk);
    check("t1_empty_in_lookup", 32'(bus.empty), 32'h1);
    check("t1_key_code", 32'(bus.key_code), 32'h1C);
    tick();
    @(negedge clk);
    check("t1_empty_after2", 32'(bus.empty), 32'h0);
    check("t1_data", 32'(bus.data_out), 32'(A_PLAIN));
    send_byte(8'hF0); send_byte(8'h1C); idle(3);
    @(negedge clk);
    check("t1_count", 32'(bus.count), 32'h1);
    pop(); idle(1);

    // 2: shifted and unshifted A
    foreach (seq2[i]) begin send_byte(seq2[i]); tick(); end
    idle(2);
    @(negedge clk);
    check("t2_count", 32'(bus.count), 32'h2);
    check("t2_first", 32'(bus.data_out), 32'h41);
    pop();
    @(negedge clk);
    check("t2_second", 32'(bus.data_out), 32'(A_PLAIN));
    pop(); idle(1);

    // 3: extended make/break leaves nothing queued
    foreach (seq3[i]) begin send_byte(seq3[i]); tick(); end
    idle(2);
    @(negedge clk);
    check("t3_count", 32'(bus.count), 32'h0);
    send_byte(8'h16); idle(2);
    @(negedge clk);
    check("t3_after_ext", 32'(bus.data_out), 32'h31);
    pop(); idle(1);

    // 4: overflow, full push+pop, clear
    repeat (DEPTH + 1) begin send_byte(8'h45); tick(); end
    idle(2);
    @(negedge clk);
    check("t4_count", 32'(bus.count), 32'(DEPTH));
    check("t4_full", 32'(bus.full), 32'h1);
    check("t4_overflow", 32'(bus.overflow), 32'h1);
    send_byte(8'h45);
    bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
    @(negedge clk);
    check("t4_count_pushpop", 32'(bus.count), 32'(DEPTH));
    clear_err();
    @(negedge clk);
    check("t4_overflow_clr", 32'(bus.overflow), 32'h0);
    repeat (DEPTH) pop();
    idle(1);

    // 5: strobe during lookup
    bus.scan_code = 8'h16; bus.scan_valid = 1'b1;
    tick(); tick();
    bus.scan_valid = 1'b0;
    idle(2);
    @(negedge clk);
    check("t5_count", 32'(bus.count), 32'h1);
    check("t5_data", 32'(bus.data_out), 32'h31);
    check("t5_overrun", 32'(bus.overrun), 32'h1);
    clear_err();
    @(negedge clk);
    check("t5_overrun_clr", 32'(bus.overrun), 32'h0);
    pop(); idle(1);

    // 6: reset after F0 with entries held
    send_byte(8'h1C); tick(); send_byte(8'h32); tick(); send_byte(8'hF0); tick();
    #2 reset_n = 1'b0;
    #2 check_reset_values("t6_rst");
    @(posedge clk); #1 reset_n = 1'b1;
    send_byte(8'h1C); idle(2);
    @(negedge clk);
    check("t6_count", 32'(bus.count), 32'h1);
    check("t6_data", 32'(bus.data_out), 32'(A_PLAIN));
    pop(); idle(1);

    // Random traffic
    repeat (2000) begin
      bus.scan_valid = ($urandom_range(99) < 35);
      bus.scan_code  = pool[$urandom_range(11)];
      bus.rd_en      = ($urandom_range(99) < 30);
      bus.clr_err    = ($urandom_range(99) < 4);
      tick();
    end
    bus.scan_valid = 1'b0; bus.clr_err = 1'b0;
    bus.rd_en = 1'b1; idle(DEPTH + 4); bus.rd_en = 1'b0;
    idle(2);
    @(negedge clk);
    check("final_empty", 32'(bus.empty), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
